// File: rtl/irrigation_zone_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_zone_scheduler
// Description : Shares one water tank and one sprinkler/dripper pair among
//               ZONES beds. The beds are served one at a time in round-robin
//               order. Each run and each settle period is timed in slow ticks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock                  system clock, rising edge
//   reset                  synchronous, active-high
//   tick                   one-clock enable pulse from the clock divisor
//   low/mid/high_water_level  tank level sensors (1 = water at that level)
//   earth_dry[ZONES]       1 = bed needs water
//   air_humidity, low_temperature  weather sensors
//   zone_valve[ZONES]      one-hot valve of the bed being irrigated
//   active_zone            index of the bed being served or settled
//   splinker_bomb          sprinkler pump
//   dripper_valvule        dripper valve
//   water_supply_valvule   tank refill valve
//   remaining              ticks left in the current run or settle period
//   alarm                  fault, or tank below the mid sensor
//   busy                   a bed is being selected, irrigated or settled
// Configuration macro
//   IRRIGATION_SENSOR_DEBOUNCE_EN : adds a tick-based stability filter after
//   the level-sensor synchronisers (DEBOUNCE_TICKS consecutive ticks).
// ============================================================================
module irrigation_zone_scheduler #(
  parameter int ZONES          = 4,
  parameter int TIMER_WIDTH    = 8,
  parameter int IRRIGATE_TICKS = 9,
  parameter int COOLDOWN_TICKS = 3,
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     low_water_level,
  input  logic                     mid_water_level,
  input  logic                     high_water_level,
  input  logic [ZONES-1:0]         earth_dry,
  input  logic                     air_humidity,
  input  logic                     low_temperature,
  output logic [ZONES-1:0]         zone_valve,
  output logic [$clog2(ZONES)-1:0] active_zone,
  output logic                     splinker_bomb,
  output logic                     dripper_valvule,
  output logic                     water_supply_valvule,
  output logic [TIMER_WIDTH-1:0]   remaining,
  output logic                     alarm,
  output logic                     busy
);

  localparam int ZW = $clog2(ZONES);
  localparam logic [TIMER_WIDTH-1:0] RUN_LOAD    = TIMER_WIDTH'(IRRIGATE_TICKS);
  localparam logic [TIMER_WIDTH-1:0] SETTLE_LOAD = TIMER_WIDTH'(COOLDOWN_TICKS);
  localparam logic [TIMER_WIDTH-1:0] ONE         = TIMER_WIDTH'(1);
  localparam logic [ZW-1:0]          LAST_ZONE   = ZW'(ZONES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_IRRIGATE = 3'd2,
    S_COOLDOWN = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t                 state;
  logic [ZW-1:0]          rr;
  logic                   sprinkle;
  logic                   fault_dirty;
  logic                   run_en;

  // --------------------------------------------------------------------------
  // Level sensors, bit order {high, mid, low}
  // --------------------------------------------------------------------------
  logic [2:0] lvl_meta;
  logic [2:0] lvl_sync;
  logic [2:0] lvl_used;

  always_ff @(posedge clock) begin
    if (reset) begin
      lvl_meta <= 3'b000;
      lvl_sync <= 3'b000;
    end else begin
      lvl_meta <= {high_water_level, mid_water_level, low_water_level};
      lvl_sync <= lvl_meta;
    end
  end

`ifdef IRRIGATION_SENSOR_DEBOUNCE_EN
  // The filtered value only follows the synchronised one after it has
  // disagreed on DEBOUNCE_TICKS consecutive ticks.
  localparam logic [TIMER_WIDTH-1:0] DEB_LAST = TIMER_WIDTH'(DEBOUNCE_TICKS - 1);

  for (genvar s = 0; s < 3; s++) begin : g_filter
    logic                   filt;
    logic [TIMER_WIDTH-1:0] diff_cnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        filt     <= 1'b0;
        diff_cnt <= '0;
      end else if (tick) begin
        if (lvl_sync[s] == filt) begin
          diff_cnt <= '0;
        end else if (diff_cnt >= DEB_LAST) begin
          filt     <= lvl_sync[s];
          diff_cnt <= '0;
        end else begin
          diff_cnt <= diff_cnt + ONE;
        end
      end
    end

    assign lvl_used[s] = filt;
  end
`else
  assign lvl_used = lvl_sync;

  // Debounce depth only matters when the filter is built in.
  if (DEBOUNCE_TICKS < 1) begin : g_debounce_unused
  end
`endif

  logic lvl_low, lvl_mid, lvl_high;
  logic conflict, irrigation_ok;

  assign lvl_low       = lvl_used[0];
  assign lvl_mid       = lvl_used[1];
  assign lvl_high      = lvl_used[2];
  assign conflict      = (lvl_high & ~lvl_mid) | (lvl_mid & ~lvl_low);
  assign irrigation_ok = ~conflict & lvl_low;

  // --------------------------------------------------------------------------
  // Round-robin search: first dry bed at or after rr, wrapping. Scanning from
  // the far end lets the nearest candidate overwrite the others.
  // --------------------------------------------------------------------------
  logic          pick_found;
  logic [ZW-1:0] pick_zone;
  logic [ZW:0]   scan_sum;
  logic [ZW-1:0] scan_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_zone  = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      scan_sum = {1'b0, rr} + (ZW + 1)'(i);
      if (scan_sum >= (ZW + 1)'(ZONES)) begin
        scan_sum = scan_sum - (ZW + 1)'(ZONES);
      end
      scan_idx = scan_sum[ZW-1:0];
      if (earth_dry[scan_idx]) begin
        pick_found = 1'b1;
        pick_zone  = scan_idx;
      end
    end
  end

  logic [ZW-1:0] rr_next;
  assign rr_next = (active_zone == LAST_ZONE) ? '0 : active_zone + 1'b1;

  // --------------------------------------------------------------------------
  // Scheduler
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      rr          <= '0;
      active_zone <= '0;
      sprinkle    <= 1'b0;
      remaining   <= '0;
      fault_dirty <= 1'b0;
      run_en      <= 1'b0;
    end else begin
      run_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (conflict) begin
            state       <= S_FAULT;
            fault_dirty <= 1'b1;
          end else if ((|earth_dry) && irrigation_ok) begin
            state <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (conflict) begin
            state       <= S_FAULT;
            fault_dirty <= 1'b1;
          end else if (!pick_found) begin
            state <= S_IDLE;
          end else begin
            active_zone <= pick_zone;
            sprinkle    <= ~air_humidity & ~low_temperature & lvl_mid;
            remaining   <= RUN_LOAD;
            state       <= S_IRRIGATE;
          end
        end

        S_IRRIGATE: begin
          if (conflict) begin
            state       <= S_FAULT;
            fault_dirty <= 1'b1;
            remaining   <= '0;
          end else if (!earth_dry[active_zone] || !lvl_low ||
                       (tick && remaining <= ONE)) begin
            state     <= S_COOLDOWN;
            remaining <= SETTLE_LOAD;
            rr        <= rr_next;
          end else if (tick) begin
            remaining <= remaining - ONE;
          end
        end

        S_COOLDOWN: begin
          if (conflict) begin
            state       <= S_FAULT;
            fault_dirty <= 1'b1;
            remaining   <= '0;
          end else if (tick) begin
            if (remaining <= ONE) begin
              remaining <= '0;
              state     <= S_IDLE;
            end else begin
              remaining <= remaining - ONE;
            end
          end
        end

        S_FAULT: begin
          // fault_dirty remembers any conflict since the previous tick; a tick
          // closing a fully clean interval releases the fault.
          if (tick) begin
            if (!fault_dirty && !conflict) begin
              state <= S_IDLE;
            end
            fault_dirty <= conflict;
          end else if (conflict) begin
            fault_dirty <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from registered state
  // --------------------------------------------------------------------------
  logic irrigating;
  assign irrigating = (state == S_IRRIGATE);

  for (genvar z = 0; z < ZONES; z++) begin : g_valve
    assign zone_valve[z] = irrigating && (active_zone == ZW'(z));
  end

  assign splinker_bomb        = irrigating & sprinkle;
  assign dripper_valvule      = irrigating & ~sprinkle;
  // run_en keeps the refill valve shut while reset is held.
  assign water_supply_valvule = run_en & ~conflict & ~lvl_high & (state != S_FAULT);
  assign alarm                = (state == S_FAULT) | ~lvl_mid;
  assign busy                 = (state == S_SELECT) | irrigating | (state == S_COOLDOWN);

endmodule
`default_nettype wire

// File: tb/tb_irrigation_zone_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_irrigation_zone_scheduler
// Description : Self-checking bench for irrigation_zone_scheduler. Expected
//               zone order, run/settle lengths and actuator mode come from a
//               round-robin reference computed from the bed pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irrigation_zone_scheduler;

  localparam int NZ      = 4;
  localparam int RUN_T   = 9;
  localparam int SETTLE_T = 3;
`ifdef IRRIGATION_SENSOR_DEBOUNCE_EN
  localparam int SETTLE_CLKS = 60;
  localparam int FAULT_LIMIT = 60;
`else
  localparam int SETTLE_CLKS = 4;
  localparam int FAULT_LIMIT = 3;
`endif

  logic          clock, reset, tick;
  logic          low_water_level, mid_water_level, high_water_level;
  logic [NZ-1:0] earth_dry;
  logic          air_humidity, low_temperature;
  logic [NZ-1:0] zone_valve;
  logic [1:0]    active_zone;
  logic          splinker_bomb, dripper_valvule, water_supply_valvule;
  logic [7:0]    remaining;
  logic          alarm, busy;

  int checks = 0;
  int fails  = 0;
  int tick_period = 3;
  int ref_rr = 0;

  irrigation_zone_scheduler #(
    .ZONES(NZ), .TIMER_WIDTH(8), .IRRIGATE_TICKS(RUN_T),
    .COOLDOWN_TICKS(SETTLE_T), .DEBOUNCE_TICKS(2)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .low_water_level(low_water_level), .mid_water_level(mid_water_level),
    .high_water_level(high_water_level), .earth_dry(earth_dry),
    .air_humidity(air_humidity), .low_temperature(low_temperature),
    .zone_valve(zone_valve), .active_zone(active_zone),
    .splinker_bomb(splinker_bomb), .dripper_valvule(dripper_valvule),
    .water_supply_valvule(water_supply_valvule), .remaining(remaining),
    .alarm(alarm), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tick pulses change 2 time units after a rising edge, so a value seen at
  // a falling edge is the one the next rising edge consumes.
  initial begin
    int phase;
    phase = 0;
    tick  = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      phase++;
      if (phase >= tick_period) begin
        phase = 0;
        tick  = 1'b1;
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Reference round-robin choice: first dry bed at or after 'from', wrapping.
  function automatic int pick_ref(input logic [NZ-1:0] dry, input int from);
    logic [NZ-1:0] rot;
    for (int k = 0; k < NZ; k++) begin
      rot = dry >> ((from + k) % NZ);
      if (rot[0]) return (from + k) % NZ;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; low_water_level = 1'b1; mid_water_level = 1'b1;
    high_water_level = 1'b0; earth_dry = '0; air_humidity = 1'b0;
    low_temperature = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (zone_valve !== 4'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_valves: valve=%b busy=%b required 0000/0", zone_valve, busy);
    end
    checks++;
    if (remaining !== 8'd0 || active_zone !== 2'd0) begin
      fails++; $display("FAIL reset_counters: remaining=%0d zone=%0d required 0/0", remaining, active_zone);
    end
    checks++;
    if (splinker_bomb !== 1'b0 || dripper_valvule !== 1'b0 || water_supply_valvule !== 1'b0) begin
      fails++; $display("FAIL reset_actuators: spr=%b drip=%b refill=%b required 0/0/0",
                        splinker_bomb, dripper_valvule, water_supply_valvule);
    end
    reset = 1'b0;
    repeat (SETTLE_CLKS) @(negedge clock);
    checks++;
    if (alarm !== 1'b0 || water_supply_valvule !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset_tank: alarm=%b refill=%b busy=%b required 0/1/0",
                        alarm, water_supply_valvule, busy);
    end
    ref_rr = 0;
  endtask

  task automatic test_round_robin(input int iters);
    logic [NZ-1:0] dry;
    logic          exp_spr;
    int            z, lat, cnt, guard, bad;
    for (int it = 0; it < iters; it++) begin
      if (it < 3) begin
        dry = 4'b1010; air_humidity = 1'b0; low_temperature = 1'b0;
      end else begin
        dry = 4'($urandom_range(1, 15));
        air_humidity = 1'($urandom_range(0, 1));
        low_temperature = 1'($urandom_range(0, 1));
        tick_period = $urandom_range(2, 5);
      end
      earth_dry = dry;
      z = pick_ref(dry, ref_rr);
      exp_spr = !air_humidity && !low_temperature;
      lat = 0;
      while (zone_valve === 4'b0 && lat < 20) begin
        @(negedge clock); lat++;
      end
      checks++;
      if (lat !== 2) begin
        fails++; $display("FAIL rr_latency it%0d: clocks=%0d required 2", it, lat);
      end
      checks++;
      if (zone_valve !== 4'(1 << z) || active_zone !== 2'(z)) begin
        fails++; $display("FAIL rr_zone it%0d: valve=%b zone=%0d required zone %0d", it, zone_valve, active_zone, z);
      end
      checks++;
      if (splinker_bomb !== exp_spr || dripper_valvule !== !exp_spr) begin
        fails++; $display("FAIL rr_mode it%0d: spr=%b drip=%b required spr=%b", it, splinker_bomb, dripper_valvule, exp_spr);
      end
      cnt = 0; guard = 0; bad = 0;
      while (zone_valve !== 4'b0 && guard < 200) begin
        if (remaining !== 8'(RUN_T - cnt)) bad++;
        if (zone_valve !== 4'(1 << z) || splinker_bomb !== exp_spr || dripper_valvule !== !exp_spr) bad++;
        if (tick) cnt++;
        if ($urandom_range(0, 5) == 0) begin
          air_humidity = ~air_humidity; low_temperature = ~low_temperature;
        end
        @(negedge clock); guard++;
      end
      checks++;
      if (bad != 0) begin
        fails++; $display("FAIL rr_run_stable it%0d: %0d bad cycles required 0", it, bad);
      end
      checks++;
      if (cnt !== RUN_T) begin
        fails++; $display("FAIL rr_run_ticks it%0d: ticks=%0d required %0d", it, cnt, RUN_T);
      end
      checks++;
      if (remaining !== 8'(SETTLE_T) || busy !== 1'b1) begin
        fails++; $display("FAIL rr_settle_load it%0d: remaining=%0d busy=%b required %0d/1", it, remaining, busy, SETTLE_T);
      end
      cnt = 0; guard = 0;
      while (busy === 1'b1 && guard < 200) begin
        if (tick) cnt++;
        @(negedge clock); guard++;
      end
      checks++;
      if (cnt !== SETTLE_T) begin
        fails++; $display("FAIL rr_settle_ticks it%0d: ticks=%0d required %0d", it, cnt, SETTLE_T);
      end
      ref_rr = (z + 1) % NZ;
    end
    earth_dry = '0;
    @(negedge clock);
  endtask

  task automatic test_dry_clear();
    int z, guard, cnt;
    tick_period = 3;
    earth_dry = 4'b0100;
    z = pick_ref(earth_dry, ref_rr);
    guard = 0;
    while (zone_valve === 4'b0 && guard < 20) begin @(negedge clock); guard++; end
    cnt = 0;
    while (cnt < 4 && guard < 200) begin
      if (tick) cnt++;
      @(negedge clock); guard++;
    end
    checks++;
    if (zone_valve !== 4'(1 << z) || remaining !== 8'(RUN_T - 4)) begin
      fails++; $display("FAIL dry_clear_midrun: valve=%b remaining=%0d required %b/%0d",
                        zone_valve, remaining, 4'(1 << z), RUN_T - 4);
    end
    earth_dry = 4'b0000;
    @(negedge clock);
    checks++;
    if (zone_valve !== 4'b0 || remaining !== 8'(SETTLE_T) || busy !== 1'b1) begin
      fails++; $display("FAIL dry_clear_exit: valve=%b remaining=%0d busy=%b required 0000/%0d/1",
                        zone_valve, remaining, busy, SETTLE_T);
    end
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin @(negedge clock); guard++; end
    ref_rr = (z + 1) % NZ;
  endtask

  task automatic test_conflict();
    int guard, waited;
    tick_period = 3;
    earth_dry = 4'($urandom_range(1, 15));
    guard = 0;
    while (zone_valve === 4'b0 && guard < 20) begin @(negedge clock); guard++; end
    repeat (4) @(negedge clock);
    high_water_level = 1'b1; mid_water_level = 1'b0;
    waited = 0;
    while (zone_valve !== 4'b0 && waited < 100) begin @(negedge clock); waited++; end
    checks++;
    if (waited > FAULT_LIMIT) begin
      fails++; $display("FAIL conflict_latency: clocks=%0d required <= %0d", waited, FAULT_LIMIT);
    end
    checks++;
    if (alarm !== 1'b1 || water_supply_valvule !== 1'b0 || busy !== 1'b0 ||
        splinker_bomb !== 1'b0 || dripper_valvule !== 1'b0) begin
      fails++; $display("FAIL conflict_outputs: alarm=%b refill=%b busy=%b spr=%b drip=%b required 1/0/0/0/0",
                        alarm, water_supply_valvule, busy, splinker_bomb, dripper_valvule);
    end
    repeat (3 * tick_period) @(negedge clock);
    high_water_level = 1'b0; mid_water_level = 1'b1; earth_dry = '0;
    waited = 0;
    while (alarm !== 1'b0 && waited < 200) begin @(negedge clock); waited++; end
    checks++;
    if (waited < tick_period || waited >= 200) begin
      fails++; $display("FAIL fault_release: clocks=%0d required %0d..199", waited, tick_period);
    end
    checks++;
    if (water_supply_valvule !== 1'b1 || busy !== 1'b0 || zone_valve !== 4'b0) begin
      fails++; $display("FAIL fault_idle: refill=%b busy=%b valve=%b required 1/0/0000",
                        water_supply_valvule, busy, zone_valve);
    end
  endtask

  task automatic test_dripper();
    int z, guard, bad;
    low_temperature = 1'b1; air_humidity = 1'b0;
    earth_dry = 4'($urandom_range(1, 15));
    z = pick_ref(earth_dry, ref_rr);
    guard = 0;
    while (zone_valve === 4'b0 && guard < 20) begin @(negedge clock); guard++; end
    checks++;
    if (zone_valve !== 4'(1 << z)) begin
      fails++; $display("FAIL drip_zone: valve=%b required %b", zone_valve, 4'(1 << z));
    end
    bad = 0;
    while (zone_valve !== 4'b0 && guard < 300) begin
      if (dripper_valvule !== 1'b1 || splinker_bomb !== 1'b0) bad++;
      if (guard % 2 == 0) air_humidity = ~air_humidity;
      if (guard > 8) low_temperature = 1'b0;
      @(negedge clock); guard++;
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL drip_hold: %0d bad cycles required 0", bad);
    end
    earth_dry = '0;
    while (busy === 1'b1 && guard < 400) begin @(negedge clock); guard++; end
    ref_rr = (z + 1) % NZ;
  endtask

  task automatic test_reset_midrun();
    int guard;
    earth_dry = 4'b1111;
    guard = 0;
    while (zone_valve === 4'b0 && guard < 20) begin @(negedge clock); guard++; end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (zone_valve !== 4'b0 || busy !== 1'b0 || remaining !== 8'd0 || active_zone !== 2'd0 ||
        splinker_bomb !== 1'b0 || dripper_valvule !== 1'b0 || water_supply_valvule !== 1'b0) begin
      fails++; $display("FAIL reset_midrun: valve=%b busy=%b rem=%0d zone=%0d spr=%b drip=%b refill=%b required all 0",
                        zone_valve, busy, remaining, active_zone, splinker_bomb, dripper_valvule, water_supply_valvule);
    end
    reset = 1'b0;
    earth_dry = '0;
    repeat (SETTLE_CLKS) @(negedge clock);
    earth_dry = 4'b1111;
    guard = 0;
    while (zone_valve === 4'b0 && guard < 20) begin @(negedge clock); guard++; end
    checks++;
    if (zone_valve !== 4'b0001 || active_zone !== 2'd0) begin
      fails++; $display("FAIL reset_rr: valve=%b zone=%0d required 0001/0", zone_valve, active_zone);
    end
    earth_dry = '0;
    while (busy === 1'b1 && guard < 200) begin @(negedge clock); guard++; end
    ref_rr = 1;
  endtask

`ifdef IRRIGATION_SENSOR_DEBOUNCE_EN
  task automatic test_debounce();
    int guard, bad;
    tick_period = 4;
    guard = 0;
    while (tick !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
    @(negedge clock);
    mid_water_level = 1'b0;
    bad = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == tick_period) mid_water_level = 1'b1;
      if (alarm !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL debounce_glitch: alarm cycles=%0d required 0", bad);
    end
    guard = 0;
    while (tick !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
    @(negedge clock);
    mid_water_level = 1'b0;
    bad = 0;
    for (int c = 0; c < 3 * tick_period + 4; c++) begin
      if (alarm === 1'b1) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad == 0) begin
      fails++; $display("FAIL debounce_drop: alarm cycles=%0d required > 0", bad);
    end
    mid_water_level = 1'b1;
    repeat (SETTLE_CLKS) @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin(10);
    test_dry_clear();
    test_conflict();
    test_dripper();
    test_reset_midrun();
`ifdef IRRIGATION_SENSOR_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
